// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcode values,
// controller state encoding, datapath mux select encodings and trap causes.
package multicycle_ctrl_pkg;

  // RV32I base opcodes (instr[6:0]) recognised by the controller
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Width of the memory watchdog counter; covers TIMEOUT up to 2^16-1
  localparam int WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4   = 2'd0,
    PC_IMM     = 2'd1,
    PC_RS1_IMM = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_SYSTEM  = 2'd3
  } trap_cause_t;

  // Opcodes that execute normally (SYSTEM is handled separately as a trap)
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Opcodes that write a destination register in WB
  function automatic logic writes_rd(input logic [6:0] op);
    logic wr;
    case (op)
      OP_R, OP_I_ALU, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: wr = 1'b1;
      default:                                                  wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Memory-request watchdog: counts consecutive cycles a request waits for
// ready and flags the cycle in which the wait reaches TIMEOUT cycles.
module mem_watchdog
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count_reg;
  logic [WDOG_W-1:0] count_next;

  // Clear has priority so a ready or state change restarts the wait window
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + WDOG_W'(1);
    end
  end

  // Wait-cycle counter register
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // The current cycle is the TIMEOUT-th wait; enable already excludes ready,
  // so a ready arriving in this cycle suppresses the timeout
  assign timeout = enable && (count_reg == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, drives datapath enables/muxes, owns the
// memory handshakes, the memory watchdog and the retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_pc,
  output logic             alu_b_imm,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  ctrl_state_t       state_reg;
  ctrl_state_t       state_next;
  trap_cause_t       cause_reg;
  trap_cause_t       cause_next;
  logic [6:0]        op_reg;
  logic [6:0]        op_next;
  logic              run_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wdog_enable;
  logic              wdog_clear;
  logic              wdog_timeout;
  logic              is_store;
  logic              is_mem_op;

  assign is_store  = (op_reg == OP_STORE);
  assign is_mem_op = (op_reg == OP_LOAD) || (op_reg == OP_STORE);

  // State, latched opcode, trap cause and run flag; run_reg keeps FETCH idle
  // for the first cycle after reset so imem_req rises one cycle later
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= ST_FETCH;
      cause_reg <= CAUSE_NONE;
      op_reg    <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      op_reg    <= op_next;
      run_reg   <= 1'b1;
    end
  end

  // Next-state logic: opcode classification in DECODE, handshakes and timeouts
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    op_next    = op_reg;
    case (state_reg)
      ST_FETCH: begin
        if (run_reg) begin
          if (imem_ready) begin
            state_next = ST_DECODE;
          end else if (wdog_timeout) begin
            state_next = ST_TRAP;
            cause_next = CAUSE_TIMEOUT;
          end
        end
      end
      ST_DECODE: begin
        op_next = opcode;
        if (opcode == OP_SYSTEM) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_SYSTEM;
        end else if (!is_legal_op(opcode)) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = is_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_next = is_store ? ST_FETCH : ST_WB;
        end else if (wdog_timeout) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Output decode from registered state and latched opcode. Only ir_we and the
  // store-completion strobes look at ready: the IR must capture data in the
  // ready cycle, and a store must advance the PC before the next fetch
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    trap      = 1'b0;
    if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
      alu_a_pc  = (op_reg == OP_AUIPC) || (op_reg == OP_JAL);
      alu_b_imm = (op_reg == OP_I_ALU) || (op_reg == OP_LOAD) ||
                  (op_reg == OP_STORE) || (op_reg == OP_JALR) ||
                  (op_reg == OP_JAL)   || (op_reg == OP_LUI)  ||
                  (op_reg == OP_AUIPC);
    end
    case (state_reg)
      ST_FETCH: begin
        imem_req = run_reg;
        ir_we    = run_reg && imem_ready;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (is_store && dmem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_WB: begin
        retire = 1'b1;
        pc_we  = 1'b1;
        rf_we  = writes_rd(op_reg);
        case (op_reg)
          OP_LOAD:         wb_sel = WB_MEM;
          OP_JAL, OP_JALR: wb_sel = WB_PC4;
          OP_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
        case (op_reg)
          OP_JAL:    pc_sel = PC_IMM;
          OP_JALR:   pc_sel = PC_RS1_IMM;
          OP_BRANCH: pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
          default:   pc_sel = PC_PLUS4;
        endcase
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign trap_cause = cause_reg;

  // Watchdog counts waiting request cycles; restarts on ready or state change
  assign wdog_enable = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
  assign wdog_clear  = (imem_req && imem_ready) || (dmem_req && dmem_ready) ||
                       (state_next != state_reg);

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_watchdog (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (wdog_clear),
    .enable  (wdog_enable),
    .timeout (wdog_timeout)
  );

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (retire) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction streams
// and handshake delays compared with a latency/field model of the controller.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [6:0] T_R      = 7'h33;
  localparam logic [6:0] T_I      = 7'h13;
  localparam logic [6:0] T_LOAD   = 7'h03;
  localparam logic [6:0] T_STORE  = 7'h23;
  localparam logic [6:0] T_BRANCH = 7'h63;
  localparam logic [6:0] T_JAL    = 7'h6F;
  localparam logic [6:0] T_JALR   = 7'h67;
  localparam logic [6:0] T_LUI    = 7'h37;
  localparam logic [6:0] T_AUIPC  = 7'h17;
  localparam logic [6:0] T_FENCE  = 7'h0F;
  localparam logic [6:0] T_SYSTEM = 7'h73;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       opcode = '0;
  logic             branch_taken = 1'b0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]       pc_sel, wb_sel, trap_cause;
  logic             alu_a_pc, alu_b_imm, rf_we, retire, trap;
  logic [CNT_W-1:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [6:0] legal_ops [10] = '{T_R, T_I, T_LOAD, T_STORE, T_BRANCH,
                                 T_JAL, T_JALR, T_LUI, T_AUIPC, T_FENCE};

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .retired_cnt(retired_cnt), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference tables: what the WB/retire cycle must show for each opcode
  function automatic logic exp_rf_we(input logic [6:0] op);
    return op inside {T_R, T_I, T_LOAD, T_JAL, T_JALR, T_LUI, T_AUIPC};
  endfunction

  function automatic logic [1:0] exp_wb_sel(input logic [6:0] op);
    if (op == T_LOAD) return 2'd1;
    if (op == T_JAL || op == T_JALR) return 2'd2;
    if (op == T_LUI) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_pc_sel(input logic [6:0] op, input logic tk);
    if (op == T_JAL) return 2'd1;
    if (op == T_JALR) return 2'd2;
    if (op == T_BRANCH) return tk ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction

  // Cycles from first fetch cycle to retire cycle inclusive
  function automatic int exp_latency(input logic [6:0] op, input int id, input int dd);
    int lat;
    lat = (id + 1) + 1 + 1;
    if (op == T_LOAD) lat += (dd + 1) + 1;
    else if (op == T_STORE) lat += dd + 1;
    else lat += 1;
    return lat;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  // Runs one instruction from its first FETCH cycle to its retire cycle.
  // id/dd = wait cycles before imem/dmem ready; ready is random outside windows.
  task automatic run_instr(input logic [6:0] op, input int id, input int dd,
                           input logic tk, input string tag);
    int cyc = 0, iw = 0, dw = 0, dreq = 0, irwe = 0, lat;
    bit done = 0, we_seen = 0, trap_seen = 0;
    logic r_rf = 0, r_pcwe = 0, r_apc = 0;
    logic [1:0] r_wb = 0, r_pc = 0;
    lat = exp_latency(op, id, dd);
    opcode = op;
    branch_taken = tk;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      imem_ready = imem_req ? (iw == id) : 1'($urandom_range(0, 1));
      dmem_ready = dmem_req ? (dw == dd) : 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (retired_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL %s retired_cnt got %0d exp %0d", tag, retired_cnt, exp_cnt);
        end
        checks++;
        if ({retire, pc_we, rf_we, imem_req} !== 4'b0001) begin
          errors++;
          $display("FAIL %s first_cycle {retire,pc_we,rf_we,imem_req} got %b exp 0001",
                   tag, {retire, pc_we, rf_we, imem_req});
        end
      end
      if (imem_req && !imem_ready) iw++;
      if (dmem_req) begin
        dreq++;
        if (dmem_we) we_seen = 1;
        if (!dmem_ready) dw++;
      end
      if (ir_we) irwe++;
      if (trap) trap_seen = 1;
      if (retire) begin
        done = 1;
        r_rf = rf_we; r_pcwe = pc_we; r_apc = alu_a_pc; r_wb = wb_sel; r_pc = pc_sel;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s no_retire within %0d cycles", tag, cyc);
    end else begin
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s latency got %0d exp %0d", tag, cyc, lat);
      end
      checks++;
      if (irwe != 1 || trap_seen) begin
        errors++;
        $display("FAIL %s ir_we_pulses got %0d trap %0d exp 1 trap 0", tag, irwe, trap_seen);
      end
      checks++;
      if (dreq != ((op == T_LOAD || op == T_STORE) ? dd + 1 : 0) || we_seen != (op == T_STORE)) begin
        errors++;
        $display("FAIL %s dmem_req_cycles got %0d we %0d", tag, dreq, we_seen);
      end
      checks++;
      if ({r_pcwe, r_rf, r_pc, r_apc} !== {1'b1, exp_rf_we(op), exp_pc_sel(op, tk), op == T_AUIPC || op == T_JAL}) begin
        errors++;
        $display("FAIL %s retire_fields {pc_we,rf_we,pc_sel,alu_a_pc} got %b exp %b", tag,
                 {r_pcwe, r_rf, r_pc, r_apc},
                 {1'b1, exp_rf_we(op), exp_pc_sel(op, tk), op == T_AUIPC || op == T_JAL});
      end
      if (op != T_STORE) begin
        checks++;
        if (r_wb !== exp_wb_sel(op)) begin
          errors++;
          $display("FAIL %s wb_sel got %0d exp %0d", tag, r_wb, exp_wb_sel(op));
        end
      end
      exp_cnt = exp_cnt + 1'b1;
    end
    $display("txn %s op=%h id=%0d dd=%0d tk=%0d cycles=%0d", tag, op, id, dd, tk, cyc);
  endtask

  // Consumes one FETCH cycle with imem_ready low and checks the counter
  task automatic check_count(input string tag);
    @(negedge CLK);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (retired_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s retired_cnt got %0d exp %0d", tag, retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      opcode = 7'($urandom);
      #1;
      checks++;
      if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_pc, alu_b_imm,
           rf_we, wb_sel, retire, trap, trap_cause, retired_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got nonzero imem_req=%b ir_we=%b trap=%b cnt=%0d exp all 0",
                 imem_req, ir_we, trap, retired_cnt);
      end
    end
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early imem_req got %b exp 0", imem_req);
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({imem_req, trap} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release {imem_req,trap} got %b exp 10", {imem_req, trap});
    end
    $display("txn reset done");
  endtask

  task automatic test_add();
    do_reset();
    run_instr(T_R, 0, 0, 1'b0, "add");
    check_count("add_count");
  endtask

  task automatic test_load_delay();
    do_reset();
    run_instr(T_LOAD, 0, 3, 1'b0, "lw_delay3");
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(T_BRANCH, 0, 0, 1'b1, "beq_taken");
    run_instr(T_BRANCH, 0, 0, 1'b0, "beq_not_taken");
    check_count("beq_count");
  endtask

  // Back-to-back random legal instructions; the 4-bit counter wraps
  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_trap_op(input logic [6:0] op, input logic [1:0] cause, input string tag);
    int cyc = 0, iw = 0, id;
    bit ret_seen = 0, trapped = 0;
    id = $urandom_range(0, TIMEOUT - 1);
    do_reset();
    opcode = op;
    while (!trapped && cyc < 30) begin
      @(negedge CLK);
      imem_ready = 1'b0;
      #1;
      imem_ready = imem_req ? (iw == id) : 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (imem_req && !imem_ready) iw++;
      if (retire) ret_seen = 1;
      if (trap) trapped = 1;
    end
    checks++;
    if (!trapped || cyc != id + 3 || trap_cause !== cause || imem_req !== 1'b0 || ret_seen) begin
      errors++;
      $display("FAIL %s trap_entry trapped=%0d cyc=%0d cause=%0d imem_req=%b retire=%0d exp cyc=%0d cause=%0d",
               tag, trapped, cyc, trap_cause, imem_req, ret_seen, id + 3, cause);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({trap, trap_cause} !== {1'b1, cause} ||
          {imem_req, dmem_req, ir_we, pc_we, rf_we, retire} !== '0) begin
        errors++;
        $display("FAIL %s trap_hold trap=%b cause=%0d strobes=%b exp trap=1 cause=%0d strobes=0",
                 tag, trap, trap_cause, {imem_req, dmem_req, ir_we, pc_we, rf_we, retire}, cause);
      end
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if ({trap, trap_cause} !== 3'b000) begin
      errors++;
      $display("FAIL %s trap_clear got trap=%b cause=%0d exp 0 0", tag, trap, trap_cause);
    end
    reset = 1'b0;
    imem_ready = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({imem_req, trap} !== 2'b10) begin
      errors++;
      $display("FAIL %s post_reset_fetch {imem_req,trap} got %b exp 10", tag, {imem_req, trap});
    end
    $display("txn %s op=%h id=%0d trap_cycle=%0d", tag, op, id, cyc);
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    test_trap_op(7'h7F, 2'd1, "illegal_7f");
    test_trap_op(T_SYSTEM, 2'd3, "system");
    for (int n = 0; n < 3; n++) begin
      do begin
        op = 7'($urandom);
      end while (is_legal(op) || op == T_SYSTEM);
      test_trap_op(op, 2'd1, "illegal_rand");
    end
  endtask

  // Ready stuck low: trap in the cycle after the TIMEOUT-th wait, request dropped
  task automatic test_timeout(input bit on_dmem, input string tag);
    int cyc = 0, exp_cyc;
    bit trapped = 0;
    exp_cyc = on_dmem ? 3 + TIMEOUT + 1 : TIMEOUT + 1;
    do_reset();
    opcode = T_LOAD;
    while (!trapped && cyc < 30) begin
      @(negedge CLK);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      imem_ready = on_dmem ? imem_req : 1'b0;
      #1;
      cyc++;
      if (trap) trapped = 1;
    end
    checks++;
    if (!trapped || cyc != exp_cyc || trap_cause !== 2'd2 || {imem_req, dmem_req} !== 2'b00) begin
      errors++;
      $display("FAIL %s timeout trapped=%0d cyc=%0d cause=%0d req=%b exp cyc=%0d cause=2 req=00",
               tag, trapped, cyc, trap_cause, {imem_req, dmem_req}, exp_cyc);
    end
    $display("txn %s trap_cycle=%0d", tag, cyc);
    // Ready arriving on the last permitted wait cycle must win
    do_reset();
    if (on_dmem) run_instr(T_LOAD, 0, TIMEOUT - 1, 1'b0, "dmem_ready_at_limit");
    else run_instr(T_R, TIMEOUT - 1, 0, 1'b0, "imem_ready_at_limit");
  endtask

  task automatic test_reset_mid_mem();
    int cyc = 0, dcyc = 0;
    do_reset();
    run_instr(T_I, 0, 0, 1'b0, "pre_mem");
    opcode = T_LOAD;
    while (dcyc < 2 && cyc < 20) begin
      @(negedge CLK);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      imem_ready = imem_req;
      #1;
      cyc++;
      if (dmem_req) dcyc++;
    end
    checks++;
    if (dcyc < 2) begin
      errors++;
      $display("FAIL mid_mem_reach dmem_req_cycles got %0d exp 2", dcyc);
    end
    @(negedge CLK);
    reset = 1'b1;
    dmem_ready = 1'b0;
    imem_ready = 1'b0;
    @(negedge CLK);
    #1;
    checks++;
    if ({dmem_req, imem_req, retire, trap} !== 4'b0000 || retired_cnt !== '0) begin
      errors++;
      $display("FAIL mid_mem_reset dmem_req=%b imem_req=%b cnt=%0d exp 0 0 0",
               dmem_req, imem_req, retired_cnt);
    end
    reset = 1'b0;
    exp_cnt = '0;
    dmem_ready = 1'b1;
    @(negedge CLK);
    #1;
    checks++;
    if ({imem_req, dmem_req, retire, pc_we, rf_we} !== 5'b10000) begin
      errors++;
      $display("FAIL late_dmem_ready {imem_req,dmem_req,retire,pc_we,rf_we} got %b exp 10000",
               {imem_req, dmem_req, retire, pc_we, rf_we});
    end
    run_instr(T_R, $urandom_range(0, TIMEOUT - 2), 0, 1'b0, "after_mid_mem_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_delay();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout(1'b0, "imem_timeout");
    test_timeout(1'b1, "dmem_timeout");
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
